// File: rtl/ddr_cmd_scheduler.sv
// Single-bank open-page DRAM command scheduler: turns host read/write requests
// into timed ACT/RD/WR/PR/REF pulses for the DRAM timing emulator.
module ddr_cmd_scheduler #(
    parameter int WIDTH = 4,
    parameter int ROWS  = 131072,
    parameter int COLS  = 1024,
    parameter int TRCD  = 3,
    parameter int TRP   = 3,
    parameter int TRAS  = 6,
    parameter int TWR   = 2,
    parameter int TRFC  = 8,
    parameter int TREFI = 200
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     halt,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [$clog2(ROWS)-1:0]  req_row,
    input  logic [$clog2(COLS)-1:0]  req_col,
    input  logic [WIDTH-1:0]         req_data,
    output logic                     ACT,
    output logic                     RD,
    output logic                     WR,
    output logic                     PR,
    output logic                     REF,
    output logic [$clog2(ROWS)-1:0]  row,
    output logic [$clog2(COLS)-1:0]  column,
    output logic [WIDTH-1:0]         dq_reg,
    output logic                     row_open,
    output logic [$clog2(ROWS)-1:0]  open_row,
    output logic [2:0]               dbg_state
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int TW = 8;
    localparam int FW = $clog2(TREFI);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ACT_WAIT = 3'd1,
        S_OPEN     = 3'd2,
        S_PRE      = 3'd3,
        S_PRE_WAIT = 3'd4,
        S_REF      = 3'd5,
        S_REF_WAIT = 3'd6
    } state_t;

    state_t           r_state, w_state_n;
    logic             r_hold_v, r_hold_write;
    logic [RW-1:0]    r_hold_row;
    logic [CW-1:0]    r_hold_col;
    logic [WIDTH-1:0] r_hold_data;
    logic             r_act, r_rd, r_wr, r_pr, r_ref;
    logic [RW-1:0]    r_row, r_open_row;
    logic [CW-1:0]    r_col;
    logic [WIDTH-1:0] r_dq;
    logic             r_row_open;
    logic [TW-1:0]    r_cnt_act, r_cnt_pr, r_cnt_wr, r_cnt_ref;
    logic [FW-1:0]    r_refi;
    logic             r_ref_pending;

    logic             w_act, w_rd, w_wr, w_pr, w_ref, w_any;
    logic             w_hold_set, w_hold_clr, w_accept, w_hit;
    logic [RW-1:0]    w_cmd_row;
    logic [CW-1:0]    w_cmd_col;
    logic [WIDTH-1:0] w_cmd_dq;
    logic             w_trcd_ok, w_tras_ok, w_twr_ok, w_trp_ok, w_trfc_ok;
    logic [FW-1:0]    w_refi_inc;

    // Counters hold "edges elapsed since the command, minus one" and saturate,
    // so a command registered on this edge is T cycles after one at cnt == T-1.
    function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
        return (v == {TW{1'b1}}) ? v : v + 1'b1;
    endfunction

    assign w_trcd_ok  = r_cnt_act >= TW'(TRCD - 1);
    assign w_tras_ok  = r_cnt_act >= TW'(TRAS - 1);
    assign w_twr_ok   = r_cnt_wr  >= TW'(TWR - 1);
    assign w_trp_ok   = r_cnt_pr  >= TW'(TRP - 1);
    assign w_trfc_ok  = r_cnt_ref >= TW'(TRFC - 1);
    assign w_refi_inc = r_refi + 1'b1;

    // Handshake: a request transfers on a rising edge where req_valid and
    // req_ready are both high; req_ready is low during and while in reset.
    assign req_ready = rst_n & ~halt & ~r_ref_pending &
                       ((r_state == S_IDLE) | ((r_state == S_OPEN) & ~r_hold_v));
    assign w_accept  = req_valid & req_ready;
    assign w_hit     = (req_row == r_open_row);
    assign w_any     = w_act | w_rd | w_wr | w_pr | w_ref;

    always_comb begin
        w_state_n  = r_state;
        w_act      = 1'b0;
        w_rd       = 1'b0;
        w_wr       = 1'b0;
        w_pr       = 1'b0;
        w_ref      = 1'b0;
        w_hold_set = 1'b0;
        w_hold_clr = 1'b0;
        w_cmd_row  = r_row;
        w_cmd_col  = r_col;
        w_cmd_dq   = r_dq;
        case (r_state)
            S_IDLE: begin
                if (r_ref_pending) begin
                    w_state_n = S_REF;
                end else if (w_accept) begin
                    w_act      = 1'b1;
                    w_cmd_row  = req_row;
                    w_hold_set = 1'b1;
                    w_state_n  = S_ACT_WAIT;
                end
            end
            S_ACT_WAIT: begin
                if (w_trcd_ok) begin
                    w_wr       = r_hold_write;
                    w_rd       = ~r_hold_write;
                    w_cmd_row  = r_hold_row;
                    w_cmd_col  = r_hold_col;
                    w_cmd_dq   = r_hold_data;
                    w_hold_clr = 1'b1;
                    w_state_n  = S_OPEN;
                end
            end
            S_OPEN: begin
                if (r_ref_pending) begin
                    w_state_n = S_PRE;
                end else if (w_accept) begin
                    if (w_hit) begin
                        w_wr      = req_write;
                        w_rd      = ~req_write;
                        w_cmd_row = req_row;
                        w_cmd_col = req_col;
                        w_cmd_dq  = req_data;
                    end else begin
                        w_hold_set = 1'b1;
                        w_state_n  = S_PRE;
                    end
                end
            end
            S_PRE: begin
                if (w_tras_ok && w_twr_ok) begin
                    w_pr      = 1'b1;
                    w_cmd_row = r_open_row;
                    w_state_n = S_PRE_WAIT;
                end
            end
            S_PRE_WAIT: begin
                if (w_trp_ok) begin
                    if (r_ref_pending) begin
                        w_ref     = 1'b1;
                        w_state_n = S_REF_WAIT;
                    end else if (r_hold_v) begin
                        w_act     = 1'b1;
                        w_cmd_row = r_hold_row;
                        w_state_n = S_ACT_WAIT;
                    end else begin
                        w_state_n = S_IDLE;
                    end
                end
            end
            S_REF: begin
                if (w_trp_ok) begin
                    w_ref     = 1'b1;
                    w_state_n = S_REF_WAIT;
                end
            end
            S_REF_WAIT: begin
                if (w_trfc_ok) begin
                    if (r_hold_v) begin
                        w_act     = 1'b1;
                        w_cmd_row = r_hold_row;
                        w_state_n = S_ACT_WAIT;
                    end else begin
                        w_state_n = S_IDLE;
                    end
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_hold_v      <= 1'b0;
            r_hold_write  <= 1'b0;
            r_hold_row    <= '0;
            r_hold_col    <= '0;
            r_hold_data   <= '0;
            r_act         <= 1'b0;
            r_rd          <= 1'b0;
            r_wr          <= 1'b0;
            r_pr          <= 1'b0;
            r_ref         <= 1'b0;
            r_row         <= '0;
            r_col         <= '0;
            r_dq          <= '0;
            r_row_open    <= 1'b0;
            r_open_row    <= '0;
            r_cnt_act     <= '1;
            r_cnt_pr      <= '1;
            r_cnt_wr      <= '1;
            r_cnt_ref     <= '1;
            r_refi        <= '0;
            r_ref_pending <= 1'b0;
        end else if (halt) begin
            // Frozen: pending work resumes on the first non-halted edge.
            r_act <= 1'b0;
            r_rd  <= 1'b0;
            r_wr  <= 1'b0;
            r_pr  <= 1'b0;
            r_ref <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_act   <= w_act;
            r_rd    <= w_rd;
            r_wr    <= w_wr;
            r_pr    <= w_pr;
            r_ref   <= w_ref;
            if (w_any) begin
                r_row <= w_cmd_row;
                r_col <= w_cmd_col;
                r_dq  <= w_cmd_dq;
            end
            if (w_hold_set) begin
                r_hold_v     <= 1'b1;
                r_hold_write <= req_write;
                r_hold_row   <= req_row;
                r_hold_col   <= req_col;
                r_hold_data  <= req_data;
            end else if (w_hold_clr) begin
                r_hold_v <= 1'b0;
            end
            if (w_rd || w_wr) begin
                r_row_open <= 1'b1;
                r_open_row <= w_cmd_row;
            end else if (w_pr) begin
                r_row_open <= 1'b0;
            end
            r_cnt_act <= w_act ? '0 : sat_inc(r_cnt_act);
            r_cnt_pr  <= w_pr  ? '0 : sat_inc(r_cnt_pr);
            r_cnt_wr  <= w_wr  ? '0 : sat_inc(r_cnt_wr);
            r_cnt_ref <= w_ref ? '0 : sat_inc(r_cnt_ref);
            if (w_ref) begin
                r_refi        <= '0;
                r_ref_pending <= 1'b0;
            end else if (!r_ref_pending) begin
                r_refi <= w_refi_inc;
                if (w_refi_inc == FW'(TREFI - 1)) begin
                    r_ref_pending <= 1'b1;
                end
            end
        end
    end

    assign ACT       = r_act;
    assign RD        = r_rd;
    assign WR        = r_wr;
    assign PR        = r_pr;
    assign REF       = r_ref;
    assign row       = r_row;
    assign column    = r_col;
    assign dq_reg    = r_dq;
    assign row_open  = r_row_open;
    assign open_row  = r_open_row;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_ddr_cmd_scheduler.sv
// Directed bench for ddr_cmd_scheduler: per-edge vector tables for the basic
// command flows, plus hand-written refresh, halt and async-reset sequences.
module tb_ddr_cmd_scheduler;

    localparam int TRP  = 3;
    localparam int TRFC = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        halt = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [16:0] req_row = '0;
    logic [9:0]  req_col = '0;
    logic [3:0]  req_data = '0;
    logic        ACT, RD, WR, PR, REF;
    logic [16:0] row;
    logic [9:0]  column;
    logic [3:0]  dq_reg;
    logic        row_open;
    logic [16:0] open_row;
    logic [2:0]  dbg_state;
    logic [4:0]  pulses;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [4:0] P_NONE = 5'b00000;
    localparam logic [4:0] P_ACT  = 5'b10000;
    localparam logic [4:0] P_RD   = 5'b01000;
    localparam logic [4:0] P_WR   = 5'b00100;
    localparam logic [4:0] P_PR   = 5'b00010;
    localparam logic [4:0] P_REF  = 5'b00001;

    ddr_cmd_scheduler dut (
        .clk(clk), .rst_n(rst_n), .halt(halt),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_row(req_row), .req_col(req_col), .req_data(req_data),
        .ACT(ACT), .RD(RD), .WR(WR), .PR(PR), .REF(REF),
        .row(row), .column(column), .dq_reg(dq_reg),
        .row_open(row_open), .open_row(open_row), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;
    assign pulses = {ACT, RD, WR, PR, REF};

    typedef struct {
        logic        rst;
        logic        v;
        logic        w;
        logic [16:0] row;
        logic [9:0]  col;
        logic [3:0]  data;
        logic [4:0]  p;
        logic [2:0]  chk;
        logic [16:0] erow;
        logic [9:0]  ecol;
        logic [3:0]  edq;
        logic        erdy;
        logic        eopen;
        logic [16:0] eorow;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic v, input logic w,
                                input logic [16:0] r, input logic [9:0] c,
                                input logic [3:0] d, input logic [4:0] p,
                                input logic [2:0] chk, input logic [16:0] erow,
                                input logic [9:0] ecol, input logic [3:0] edq,
                                input logic erdy, input logic eopen,
                                input logic [16:0] eorow);
        vec_t t;
        t.rst = rst; t.v = v; t.w = w; t.row = r; t.col = c; t.data = d;
        t.p = p; t.chk = chk; t.erow = erow; t.ecol = ecol; t.edq = edq;
        t.erdy = erdy; t.eopen = eopen; t.eorow = eorow;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input logic [16:0] r,
                         input logic [9:0] c, input logic [3:0] d);
        req_valid = v; req_write = w; req_row = r; req_col = c; req_data = d;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0);
        halt  = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pr_e, ref_e, act_e, wr_e, stray;

        // Sequence A: cold write, hit stream, late row miss.
        vecs.push_back(mk(1,1,1, 0,1,2, P_ACT, 3'b100, 0,0,0, 0,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, P_NONE,3'b000, 0,0,0, 0,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, P_NONE,3'b000, 0,0,0, 0,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, P_WR,  3'b111, 0,1,2, 1,1,0));
        vecs.push_back(mk(0,1,0, 0,7,0, P_RD,  3'b110, 0,7,0, 1,1,0));
        vecs.push_back(mk(0,1,0, 0,3,0, P_RD,  3'b110, 0,3,0, 1,1,0));
        vecs.push_back(mk(0,1,0, 0,6,0, P_RD,  3'b110, 0,6,0, 1,1,0));
        vecs.push_back(mk(0,0,0, 0,0,0, P_NONE,3'b000, 0,0,0, 1,1,0));
        vecs.push_back(mk(0,1,1, 1,5,9, P_NONE,3'b000, 0,0,0, 0,1,0));
        vecs.push_back(mk(0,0,0, 0,0,0, P_PR,  3'b100, 0,0,0, 0,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, P_NONE,3'b000, 0,0,0, 0,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, P_NONE,3'b000, 0,0,0, 0,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, P_ACT, 3'b100, 1,0,0, 0,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, P_NONE,3'b000, 0,0,0, 0,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, P_NONE,3'b000, 0,0,0, 0,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, P_WR,  3'b111, 1,5,9, 1,1,1));
        // Sequence B: miss right after the cold write, tRAS-bound precharge.
        vecs.push_back(mk(1,1,1, 0,1,2, P_ACT, 3'b100, 0,0,0, 0,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, P_NONE,3'b000, 0,0,0, 0,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, P_NONE,3'b000, 0,0,0, 0,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, P_WR,  3'b111, 0,1,2, 1,1,0));
        vecs.push_back(mk(0,1,1, 1,4,5, P_NONE,3'b000, 0,0,0, 0,1,0));
        vecs.push_back(mk(0,0,0, 0,0,0, P_NONE,3'b000, 0,0,0, 0,1,0));
        vecs.push_back(mk(0,0,0, 0,0,0, P_PR,  3'b100, 0,0,0, 0,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, P_NONE,3'b000, 0,0,0, 0,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, P_NONE,3'b000, 0,0,0, 0,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, P_ACT, 3'b100, 1,0,0, 0,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, P_NONE,3'b000, 0,0,0, 0,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, P_NONE,3'b000, 0,0,0, 0,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, P_WR,  3'b111, 1,4,5, 1,1,1));
        vecs.push_back(mk(0,1,0, 1,8,0, P_RD,  3'b110, 1,8,0, 1,1,1));

        rst_n = 1'b0;
        #12;
        check("reset_pulses", pulses, P_NONE);
        check("reset_ready", req_ready, 0);
        check("reset_row_open", row_open, 0);
        check("reset_state", dbg_state, 0);

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            drive(vecs[i].v, vecs[i].w, vecs[i].row, vecs[i].col, vecs[i].data);
            step();
            check($sformatf("v%0d_pulses", i), pulses, vecs[i].p);
            check($sformatf("v%0d_ready", i), req_ready, vecs[i].erdy);
            check($sformatf("v%0d_row_open", i), row_open, vecs[i].eopen);
            check($sformatf("v%0d_open_row", i), open_row, vecs[i].eorow);
            if (vecs[i].chk[2]) check($sformatf("v%0d_row", i), row, vecs[i].erow);
            if (vecs[i].chk[1]) check($sformatf("v%0d_col", i), column, vecs[i].ecol);
            if (vecs[i].chk[0]) check($sformatf("v%0d_dq", i), dq_reg, vecs[i].edq);
            drive(0, 0, 0, 0, 0);
        end

        // Refresh with an open row.
        do_reset();
        drive(1, 1, 0, 0, 1);
        step();
        drive(0, 0, 0, 0, 0);
        pr_e = -1; ref_e = -1; act_e = -1; stray = 0;
        for (int e = 1; e <= 320; e++) begin
            step();
            if (e == 197) check("refi_ready_before", req_ready, 1);
            if (e == 198) check("refi_ready_dropped", req_ready, 0);
            if (e >= 4 && e <= 198 && pulses != P_NONE) stray++;
            if (PR && pr_e < 0) begin
                pr_e = e;
                check("refi_pr_row_open", row_open, 0);
            end
            if (REF && ref_e < 0) begin
                ref_e = e;
                check("refi_ref_row_open", row_open, 0);
                drive(1, 0, 5, 2, 0);
            end
            if (ACT && ref_e >= 0) begin
                act_e = e;
                check("refi_act_row", row, 5);
                drive(0, 0, 0, 0, 0);
                break;
            end
        end
        check("refi_no_stray_pulses", stray, 0);
        check("refi_pr_after_pending", (pr_e > 198), 1);
        check("refi_ref_trp_after_pr", ref_e - pr_e, TRP);
        check("refi_act_seen", (act_e > 0), 1);
        check("refi_act_trfc_after_ref", (act_e - ref_e >= TRFC), 1);

        // Halt for three edges during ACT_WAIT.
        do_reset();
        drive(1, 1, 0, 1, 2);
        step();
        drive(0, 0, 0, 0, 0);
        check("halt_act", pulses, P_ACT);
        halt = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            step();
            check($sformatf("halt_e%0d_pulses", e), pulses, P_NONE);
            check($sformatf("halt_e%0d_ready", e), req_ready, 0);
        end
        halt = 1'b0;
        wr_e = -1;
        for (int e = 4; e <= 24; e++) begin
            step();
            if (pulses != P_NONE) begin
                wr_e = e;
                check("halt_cmd_is_wr", pulses, P_WR);
                check("halt_wr_col", column, 1);
                check("halt_wr_dq", dq_reg, 2);
                break;
            end
        end
        check("halt_wr_edge", wr_e, 6);

        // Asynchronous reset in the middle of PRE_WAIT.
        do_reset();
        drive(1, 1, 0, 1, 2);
        step();
        drive(0, 0, 0, 0, 0);
        repeat (3) step();
        check("ar_wr", pulses, P_WR);
        drive(1, 1, 1, 4, 5);
        step();
        drive(0, 0, 0, 0, 0);
        step();
        step();
        check("ar_pr", pulses, P_PR);
        step();
        check("ar_in_pre_wait", dbg_state, 4);
        #3 rst_n = 1'b0;
        #1;
        check("ar_pulses", pulses, P_NONE);
        check("ar_column", column, 0);
        check("ar_dq", dq_reg, 0);
        check("ar_row_open", row_open, 0);
        check("ar_ready", req_ready, 0);
        check("ar_state", dbg_state, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        stray = 0;
        for (int e = 0; e < 16; e++) begin
            step();
            if (pulses != P_NONE) stray++;
        end
        check("ar_held_request_dropped", stray, 0);
        check("ar_idle_after_release", dbg_state, 0);
        check("ar_ready_after_release", req_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr_cmd_scheduler.md
Name: ddr_cmd_scheduler

Overview:
- Single-bank, open-page command scheduler that sits between a host request port and the DRAM timing emulator (`memtimingwrp`).
- Turns read/write requests into legal ACT/RD/WR/PR/REF pulse sequences that respect tRCD, tRP, tRAS, tWR, tRFC and periodic refresh (tREFI).
- Its command outputs wire directly to the emulator's same-named command inputs.

Parameters:
- WIDTH, 4: data width of dq.
- ROWS, 131072: rows per bank; row address width is $clog2(ROWS).
- COLS, 1024: columns per row; column address width is $clog2(COLS).
- TRCD, 3: minimum cycles from ACT to RD/WR.
- TRP, 3: minimum cycles from PR to ACT/REF.
- TRAS, 6: minimum cycles from ACT to PR.
- TWR, 2: minimum cycles from WR to PR.
- TRFC, 8: minimum cycles from REF to ACT.
- TREFI, 200: refresh interval in cycles.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- halt  in  1  freeze: holds all state and counters; command outputs forced low.
- req_valid  in  1  host request valid.
- req_ready  out  1  scheduler can accept a request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_row  in  $clog2(ROWS)  request row.
- req_col  in  $clog2(COLS)  request column.
- req_data  in  WIDTH  write data.
- ACT, RD, WR, PR, REF  out  1 each  one-cycle command pulses to the emulator.
- row  out  $clog2(ROWS)  row address for the current command.
- column  out  $clog2(COLS)  column address for the current command.
- dq_reg  out  WIDTH  write data; valid while WR is high.
- row_open  out  1  a row is currently open.
- open_row  out  $clog2(ROWS)  address of the open row.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All outputs 0; state IDLE; row_open=0.
  - Held request dropped; refresh counter cleared.
  - All timing counters saturated, so constraints count as satisfied after reset.
- Outputs:
  - All outputs are registered.
  - At most one command pulse per cycle.
  - Each pulse is exactly 1 cycle long.
- Handshake:
  - A request is accepted on an edge where req_valid & req_ready.
  - Its fields are captured into a holding register.
  - req_ready = !halt & !ref_pending & (state==IDLE | (state==OPEN & holding register empty)).
- States:
  - IDLE (no row open):
    - Accepted request -> ACT pulses the next cycle with row=req_row -> ACT_WAIT.
    - ref_pending set -> REF.
  - ACT_WAIT:
    - Counts until cycle A+TRCD (A = ACT cycle).
    - Then issues RD/WR -> OPEN; row_open=1, open_row=row.
  - OPEN:
    - Row hit: the RD/WR pulse is issued the cycle after acceptance. Back-to-back hits sustain one command per cycle.
    - Row miss, or ref_pending: go to PRE.
  - PRE:
    - PR is issued at the first cycle ≥ max(A+TRAS, W+TWR), where W = last WR cycle.
    - row_open goes to 0 in the same cycle as the PR pulse -> PRE_WAIT.
  - PRE_WAIT:
    - Waits until cycle P+TRP (P = PR cycle).
    - If ref_pending -> REF; otherwise ACT for the held request -> ACT_WAIT.
  - REF:
    - Pulses REF -> REF_WAIT.
    - Clears ref_pending; restarts the refresh counter.
  - REF_WAIT:
    - Waits until R+TRFC (R = REF cycle).
    - Held request present -> ACT; otherwise -> IDLE.
- Refresh:
  - The counter increments every non-halted cycle.
  - Reaching TREFI-1 sets ref_pending, which drops req_ready.
  - Refresh wins over a newly presented request, but never aborts a held request already accepted. That request completes after REF, via the ACT path.
- Halt:
  - Counters and state freeze.
  - A pulse due in a halted cycle is issued in the first non-halted cycle; timing is measured in non-halted cycles.
- Mid-operation reset: everything returns to reset values; no partial sequence resumes.
- Address ranges: rows and columns are full-range and never wrap. Only one row is tracked; there is no bank interleaving.

Test Plan:
- Cold write:
  - Stimulus: release reset; accept write row 0, col 1, data 2 at cycle 0.
  - Required: ACT at cycle 1 with row=0; WR at cycle 4 with column=1, dq_reg=2; row_open=1, open_row=0.
- Hit stream:
  - Stimulus: after the cold write, accept reads of row 0, cols 7, 3, 6 on consecutive cycles.
  - Required: RD on three consecutive cycles carrying columns 7, 3, 6; no PR or ACT.
- Row miss:
  - Stimulus: in OPEN with ACT at cycle 1 and WR at cycle 4, present a write to row 1.
  - Required: PR at cycle max(7, 6)=7; ACT with row=1 at cycle 10; WR at cycle 13.
- Refresh with open row:
  - Stimulus: run idle with row 0 open until TREFI.
  - Required: req_ready=0 at cycle 199; PR, then REF exactly TRP later; next ACT ≥ TRFC after REF; row_open=0.
- Halt:
  - Stimulus: assert halt for 3 cycles during ACT_WAIT.
  - Required: no pulses while halted; RD/WR arrives exactly 3 cycles later than the unhalted case.
- Async reset:
  - Stimulus: drive rst_n low mid-PRE_WAIT, between clock edges.
  - Required: all outputs 0 immediately, without waiting for an edge; after release, state IDLE and the held request is lost.
